// File: rtl/pkt_class_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pkt_class_pkg : shared types, header field layout and class mapping       |
// | Revision      : 1.0                                                       |
// +--------------------------------------------------------------------------+
package pkt_class_pkg;

    localparam int TYPE_LSB = 0;
    localparam int TYPE_W   = 8;
    localparam int LEN_LSB  = 8;
    localparam int LEN_W    = 16;
    localparam int CNT_W    = 64;

    typedef enum logic [2:0] {
        CLS_FD      = 3'd0,
        CLS_MD      = 3'd1,
        CLS_FC      = 3'd2,
        CLS_OTH_OUT = 3'd3,
        CLS_ABM     = 3'd4,
        CLS_OTH_IN  = 3'd5
    } pkt_class_e;

    typedef enum logic [0:0] {
        TRK_IDLE   = 1'b0,
        TRK_IN_PKT = 1'b1
    } trk_state_e;

    function automatic pkt_class_e ob_class(
        input logic [TYPE_W-1:0] typ,
        input logic [TYPE_W-1:0] fd_type,
        input logic [TYPE_W-1:0] md_type,
        input logic [TYPE_W-1:0] fc_type
    );
        if (typ == fd_type)      return CLS_FD;
        else if (typ == md_type) return CLS_MD;
        else if (typ == fc_type) return CLS_FC;
        else                     return CLS_OTH_OUT;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pkt_frame_tracker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pkt_frame_tracker : per-stream header parse, beat count and bad check     |
// | Revision          : 1.0                                                   |
// +--------------------------------------------------------------------------+
module pkt_frame_tracker
    import pkt_class_pkg::*;
#(
    parameter int DW = 512
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [DW-1:0]     i_tdata,
    input  logic              i_tvalid,
    input  logic              i_tready,
    input  logic              i_tlast,
    output logic              o_done,
    output logic              o_is_bad,
    output logic [TYPE_W-1:0] o_type
);

    trk_state_e        r_state;
    logic [TYPE_W-1:0] r_type;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_cnt;
    logic              r_sat;

    logic              w_beat;
    logic [TYPE_W-1:0] w_hdr_type;
    logic [LEN_W-1:0]  w_hdr_len;
    logic              w_cnt_max;
    logic              w_sat_now;
    logic [LEN_W-1:0]  w_cnt_inc;
    logic              w_unused_tdata;

    assign w_beat         = i_tvalid & i_tready;
    assign w_hdr_type     = i_tdata[TYPE_LSB +: TYPE_W];
    assign w_hdr_len      = i_tdata[LEN_LSB +: LEN_W];
    assign w_cnt_max      = (r_cnt == {LEN_W{1'b1}});
    // A beat arriving while the count already sits at all-ones saturates it.
    assign w_sat_now      = r_sat | w_cnt_max;
    assign w_cnt_inc      = r_cnt + LEN_W'(1);
    assign w_unused_tdata = ^i_tdata[DW-1:LEN_LSB+LEN_W];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state  <= TRK_IDLE;
            r_type   <= '0;
            r_len    <= '0;
            r_cnt    <= '0;
            r_sat    <= 1'b0;
            o_done   <= 1'b0;
            o_is_bad <= 1'b0;
            o_type   <= '0;
        end else begin
            o_done   <= 1'b0;
            o_is_bad <= 1'b0;
            if (w_beat) begin
                case (r_state)
                    TRK_IDLE: begin
                        r_type <= w_hdr_type;
                        r_len  <= w_hdr_len;
                        r_cnt  <= LEN_W'(1);
                        r_sat  <= 1'b0;
                        if (i_tlast) begin
                            o_done   <= 1'b1;
                            o_is_bad <= (w_hdr_len != LEN_W'(1));
                            o_type   <= w_hdr_type;
                        end else begin
                            r_state <= TRK_IN_PKT;
                        end
                    end
                    TRK_IN_PKT: begin
                        r_cnt <= w_cnt_max ? r_cnt : w_cnt_inc;
                        r_sat <= w_sat_now;
                        if (i_tlast) begin
                            r_state  <= TRK_IDLE;
                            o_done   <= 1'b1;
                            o_is_bad <= (r_len == '0) | w_sat_now | (w_cnt_inc != r_len);
                            o_type   <= r_type;
                        end
                    end
                    default: r_state <= TRK_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pkt_class_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pkt_class_counter : passive two-stream AXIS tap with 7 packet counters    |
// | Revision          : 1.0                                                   |
// +--------------------------------------------------------------------------+
module pkt_class_counter
    import pkt_class_pkg::*;
#(
    parameter int          DW       = 512,
    parameter logic [7:0]  FD_TYPE  = 8'h01,
    parameter logic [7:0]  MD_TYPE  = 8'h02,
    parameter logic [7:0]  FC_TYPE  = 8'h03,
    parameter logic [7:0]  ABM_TYPE = 8'h10
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clear,
    input  logic [DW-1:0]    ob_tdata,
    input  logic             ob_tvalid,
    input  logic             ob_tready,
    input  logic             ob_tlast,
    input  logic [DW-1:0]    ib_tdata,
    input  logic             ib_tvalid,
    input  logic             ib_tready,
    input  logic             ib_tlast,
    output logic [CNT_W-1:0] fd_packets,
    output logic [CNT_W-1:0] md_packets,
    output logic [CNT_W-1:0] fc_packets,
    output logic [CNT_W-1:0] other_packets_out,
    output logic [CNT_W-1:0] abm_packets,
    output logic [CNT_W-1:0] other_packets_in,
    output logic [CNT_W-1:0] bad_packets
);

    logic              w_ob_done, w_ob_bad, w_ib_done, w_ib_bad;
    logic [TYPE_W-1:0] w_ob_type, w_ib_type;
    pkt_class_e        w_ob_cls, w_ib_cls;
    logic              w_ob_good, w_ib_good;
    logic [1:0]        w_bad_inc;

    logic [CNT_W-1:0]  r_fd_cnt, r_md_cnt, r_fc_cnt, r_oth_out_cnt;
    logic [CNT_W-1:0]  r_abm_cnt, r_oth_in_cnt, r_bad_cnt;

    pkt_frame_tracker #(.DW(DW)) u_ob_trk (
        .clk      (clk),
        .resetn   (resetn),
        .i_tdata  (ob_tdata),
        .i_tvalid (ob_tvalid),
        .i_tready (ob_tready),
        .i_tlast  (ob_tlast),
        .o_done   (w_ob_done),
        .o_is_bad (w_ob_bad),
        .o_type   (w_ob_type)
    );

    pkt_frame_tracker #(.DW(DW)) u_ib_trk (
        .clk      (clk),
        .resetn   (resetn),
        .i_tdata  (ib_tdata),
        .i_tvalid (ib_tvalid),
        .i_tready (ib_tready),
        .i_tlast  (ib_tlast),
        .o_done   (w_ib_done),
        .o_is_bad (w_ib_bad),
        .o_type   (w_ib_type)
    );

    assign w_ob_cls  = ob_class(w_ob_type, FD_TYPE, MD_TYPE, FC_TYPE);
    assign w_ib_cls  = (w_ib_type == ABM_TYPE) ? CLS_ABM : CLS_OTH_IN;
    assign w_ob_good = w_ob_done & ~w_ob_bad;
    assign w_ib_good = w_ib_done & ~w_ib_bad;
    // Both streams can retire a bad packet in the same cycle.
    assign w_bad_inc = {1'b0, w_ob_done & w_ob_bad} + {1'b0, w_ib_done & w_ib_bad};

    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            r_fd_cnt      <= '0;
            r_md_cnt      <= '0;
            r_fc_cnt      <= '0;
            r_oth_out_cnt <= '0;
            r_abm_cnt     <= '0;
            r_oth_in_cnt  <= '0;
            r_bad_cnt     <= '0;
        end else begin
            if (w_ob_good && w_ob_cls == CLS_FD)      r_fd_cnt      <= r_fd_cnt + CNT_W'(1);
            if (w_ob_good && w_ob_cls == CLS_MD)      r_md_cnt      <= r_md_cnt + CNT_W'(1);
            if (w_ob_good && w_ob_cls == CLS_FC)      r_fc_cnt      <= r_fc_cnt + CNT_W'(1);
            if (w_ob_good && w_ob_cls == CLS_OTH_OUT) r_oth_out_cnt <= r_oth_out_cnt + CNT_W'(1);
            if (w_ib_good && w_ib_cls == CLS_ABM)     r_abm_cnt     <= r_abm_cnt + CNT_W'(1);
            if (w_ib_good && w_ib_cls == CLS_OTH_IN)  r_oth_in_cnt  <= r_oth_in_cnt + CNT_W'(1);
            if (w_bad_inc != 2'd0)                    r_bad_cnt     <= r_bad_cnt + CNT_W'(w_bad_inc);
        end
    end

    assign fd_packets        = r_fd_cnt;
    assign md_packets        = r_md_cnt;
    assign fc_packets        = r_fc_cnt;
    assign other_packets_out = r_oth_out_cnt;
    assign abm_packets       = r_abm_cnt;
    assign other_packets_in  = r_oth_in_cnt;
    assign bad_packets       = r_bad_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pkt_class_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pkt_class_counter : scoreboard bench with a packet-level reference     |
// | Revision             : 1.0                                                |
// +--------------------------------------------------------------------------+
module tb_pkt_class_counter;

    localparam int DW = 512;
    typedef logic [6:0][63:0] snap_t;

    logic          clk = 1'b0;
    logic          resetn;
    logic          clear;
    logic [DW-1:0] s_tdata  [2];
    logic          s_tvalid [2];
    logic          s_tready [2];
    logic          s_tlast  [2];
    logic [63:0]   fd_packets, md_packets, fc_packets, other_packets_out;
    logic [63:0]   abm_packets, other_packets_in, bad_packets;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pkt_class_counter dut (
        .clk               (clk),
        .resetn            (resetn),
        .clear             (clear),
        .ob_tdata          (s_tdata[0]),
        .ob_tvalid         (s_tvalid[0]),
        .ob_tready         (s_tready[0]),
        .ob_tlast          (s_tlast[0]),
        .ib_tdata          (s_tdata[1]),
        .ib_tvalid         (s_tvalid[1]),
        .ib_tready         (s_tready[1]),
        .ib_tlast          (s_tlast[1]),
        .fd_packets        (fd_packets),
        .md_packets        (md_packets),
        .fc_packets        (fc_packets),
        .other_packets_out (other_packets_out),
        .abm_packets       (abm_packets),
        .other_packets_in  (other_packets_in),
        .bad_packets       (bad_packets)
    );

    // Reference model: packets tracked as (type, declared length, beats seen).
    // Counter index: 0 fd, 1 md, 2 fc, 3 other_out, 4 abm, 5 other_in, 6 bad.
    snap_t       m_cnt = '0;
    snap_t       exp_q [$];
    int          ev_q  [$];
    bit          m_in  [2] = '{0, 0};
    logic [7:0]  m_typ [2];
    int          m_len [2];
    int          m_n   [2];

    function automatic int classify(input int s, input logic [7:0] t);
        if (s == 0) begin
            if (t == 8'h01) return 0;
            if (t == 8'h02) return 1;
            if (t == 8'h03) return 2;
            return 3;
        end
        return (t == 8'h10) ? 4 : 5;
    endfunction

    always @(posedge clk) begin
        if (!resetn) begin
            m_cnt = '0;
            ev_q.delete();
            m_in = '{0, 0};
        end else begin
            if (clear) begin
                ev_q.delete();
                m_cnt = '0;
            end else begin
                while (ev_q.size() > 0) begin
                    int e;
                    e = ev_q.pop_front();
                    m_cnt[e] = m_cnt[e] + 64'd1;
                end
            end
            for (int s = 0; s < 2; s++) begin
                if (s_tvalid[s] && s_tready[s]) begin
                    if (!m_in[s]) begin
                        m_typ[s] = s_tdata[s][7:0];
                        m_len[s] = int'(s_tdata[s][23:8]);
                        m_n[s]   = 1;
                    end else begin
                        m_n[s]++;
                    end
                    if (s_tlast[s]) begin
                        m_in[s] = 0;
                        if (m_len[s] == 0 || m_n[s] != m_len[s] || m_n[s] > 65535)
                            ev_q.push_back(6);
                        else
                            ev_q.push_back(classify(s, m_typ[s]));
                    end else begin
                        m_in[s] = 1;
                    end
                end
            end
        end
        exp_q.push_back(m_cnt);
    end

    // Monitor: the counters are presented every cycle, so one snapshot per cycle.
    string names [7] = '{"fd_packets", "md_packets", "fc_packets", "other_packets_out",
                         "abm_packets", "other_packets_in", "bad_packets"};
    always @(negedge clk) begin
        snap_t act, e;
        act = {bad_packets, other_packets_in, abm_packets, other_packets_out,
               fc_packets, md_packets, fd_packets};
        if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard_empty: got no expected snapshot at %0t", $time);
        end else begin
            e = exp_q.pop_front();
            for (int i = 0; i < 7; i++) begin
                n_chk++;
                if (act[i] !== e[i]) begin
                    n_fail++;
                    $display("FAIL %s @%0t: got %h expected %h", names[i], $time, act[i], e[i]);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input int s, input logic [DW-1:0] d, input bit last, input int pct);
        bit v, r;
        int tries;
        s_tdata[s] = d;
        s_tlast[s] = last;
        tries = 0;
        do begin
            v = (pct == 0) || (tries > 50) || (($urandom % 100) >= pct);
            r = (pct == 0) || (tries > 50) || (($urandom % 100) >= pct);
            s_tvalid[s] = v;
            s_tready[s] = r;
            cyc();
            tries++;
        end while (!(v && r));
        s_tvalid[s] = 1'b0;
        s_tready[s] = 1'b0;
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int j = 0; j < DW / 32; j++) d[j*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic send(input int s, input logic [7:0] typ, input int len, input int nb,
                        input int pct, input int hold_b, input int hold_n);
        for (int b = 0; b < nb; b++) begin
            logic [DW-1:0] d;
            d = rand_data();
            if (b == 0) begin
                d[7:0]  = typ;
                d[23:8] = len[15:0];
            end
            if (b == hold_b) begin
                s_tdata[s]  = d;
                s_tlast[s]  = (b == nb - 1);
                s_tvalid[s] = 1'b1;
                s_tready[s] = 1'b0;
                repeat (hold_n) cyc();
            end
            beat(s, d, b == nb - 1, pct);
        end
    endtask

    task automatic rand_stream(input int s, input int npkt);
        for (int p = 0; p < npkt; p++) begin
            logic [7:0] typ;
            int nb, len, r;
            r = $urandom % 5;
            if (s == 0) typ = (r < 4) ? 8'(r) : 8'($urandom);
            else        typ = (r < 3) ? 8'h10 : 8'($urandom);
            nb = 1 + ($urandom % 6);
            r  = $urandom % 20;
            len = (r == 0) ? 0 : (r == 1) ? int'($urandom % 8) : nb;
            send(s, typ, len, nb, $urandom % 50, -1, 0);
            repeat ($urandom % 3) cyc();
        end
    endtask

    bit rand_done;

    initial begin
        resetn = 1'b0;
        clear  = 1'b0;
        for (int s = 0; s < 2; s++) begin
            s_tdata[s]  = '0;
            s_tvalid[s] = 1'b0;
            s_tready[s] = 1'b0;
            s_tlast[s]  = 1'b0;
        end
        repeat (3) cyc();
        resetn = 1'b1;
        repeat (2) cyc();

        // Single-beat FD packet.
        send(0, 8'h01, 1, 1, 0, -1, 0);
        repeat (4) cyc();

        // MD with a 5-cycle ready stall before beat 3, then a short MD packet.
        send(0, 8'h02, 4, 4, 0, 2, 5);
        repeat (3) cyc();
        send(0, 8'h02, 4, 3, 0, -1, 0);
        repeat (3) cyc();

        // Both streams retire a short packet in the same cycle.
        fork
            send(0, 8'h01, 3, 2, 0, -1, 0);
            send(1, 8'h10, 3, 2, 0, -1, 0);
        join
        repeat (3) cyc();

        // Back-to-back single-beat ABM packets, then an unknown inbound type.
        repeat (10) send(1, 8'h10, 1, 1, 0, -1, 0);
        send(1, 8'h55, 1, 1, 0, -1, 0);
        repeat (3) cyc();

        // FC counter wrap.
        @(negedge clk);
        #1;
        force dut.r_fc_cnt = {64{1'b1}};
        m_cnt[2] = {64{1'b1}};
        cyc();
        release dut.r_fc_cnt;
        cyc();
        send(0, 8'h03, 1, 1, 0, -1, 0);
        repeat (3) cyc();

        // Clear coinciding with an FD done pulse.
        send(0, 8'h01, 1, 1, 0, -1, 0);
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        repeat (3) cyc();

        // Reset mid-packet, then a fresh FC header.
        beat(0, {rand_data() >> 24, 16'd5, 8'h02}, 1'b0, 0);
        beat(0, rand_data(), 1'b0, 0);
        s_tdata[0]  = rand_data();
        s_tvalid[0] = 1'b1;
        s_tready[0] = 1'b1;
        resetn      = 1'b0;
        repeat (2) cyc();
        s_tvalid[0] = 1'b0;
        s_tready[0] = 1'b0;
        resetn      = 1'b1;
        cyc();
        send(0, 8'h03, 1, 1, 0, -1, 0);
        repeat (3) cyc();

        // Randomized traffic on both streams with occasional clear pulses.
        rand_done = 1'b0;
        fork
            begin
                fork
                    rand_stream(0, 150);
                    rand_stream(1, 150);
                join
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    clear = (($urandom % 200) == 0);
                    cyc();
                end
                clear = 1'b0;
            end
        join
        repeat (5) cyc();
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
